bin2bcd_disp: RTL and testbench

Upstream feeder for the four-digit seven-segment scan driver. Accepts a 16-bit binary value (for example a syscall result or a debug register) and produces the 16-bit, four-nibble word the scan driver displays. In decimal mode the word is BCD, produced by a sequential shift-and-add-3 (double-dabble) converter. In hex mode the input passes straight through. The output is held stable between updates, so the scan driver's leading-zero blanking always sees a consistent word.

---
 rtl/bin2bcd_disp.sv | 109 ++++++++++
 tb/tb_bin2bcd_disp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_disp.sv
// Display-word feeder for the seven-segment scan driver.
// Decimal mode runs a 14-step double-dabble; hex mode passes the value through.
module bin2bcd_disp (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    input  logic        hex_mode,
    output logic [15:0] disp_data,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic [13:0] sr_q, sr_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] disp_q, disp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic [15:0] acc_adj;
    logic [29:0] shifted;

    function automatic logic [3:0] adj3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign acc_adj = {adj3(acc_q[15:12]), adj3(acc_q[11:8]),
                      adj3(acc_q[7:4]),   adj3(acc_q[3:0])};
    assign shifted = {acc_adj, sr_q} << 1;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (hex_mode) begin
                        disp_d = bin;
                        done_d = 1'b1;
                        ovf_d  = 1'b0;
                    end else if (bin > 16'd9999) begin
                        disp_d = 16'h9999;
                        done_d = 1'b1;
                        ovf_d  = 1'b1;
                    end else begin
                        sr_d    = bin[13:0];
                        acc_d   = 16'h0000;
                        cnt_d   = 4'd0;
                        busy_d  = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                acc_d = shifted[29:14];
                sr_d  = shifted[13:0];
                cnt_d = cnt_q + 4'd1;
                // Last shift: publish the whole result in one step.
                if (cnt_q == 4'd13) begin
                    disp_d  = shifted[29:14];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign disp_data = disp_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_disp.sv
// Self-checking bench for bin2bcd_disp against a decimal-digit model.
// Directed plan steps followed by randomized requests.
module tb_bin2bcd_disp;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    logic        hex_mode;
    logic [15:0] disp_data;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] m_disp;
    logic        m_ovf;

    bin2bcd_disp dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (bin),
        .hex_mode  (hex_mode),
        .disp_data (disp_data),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [15:0] v, input bit hx,
                           input int poke, input int rst_at);
        logic [15:0] old;
        bit          conv;
        conv     = !hx && (v <= 16'd9999);
        old      = m_disp;
        bin      = v;
        hex_mode = hx;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        bin      = 16'($urandom);
        hex_mode = 1'($urandom);
        if (!conv) begin
            m_disp = hx ? v : 16'h9999;
            m_ovf  = !hx && (v > 16'd9999);
            chk("imm_disp", disp_data, m_disp);
            chk("imm_done", 16'(done), 16'd1);
            chk("imm_busy", 16'(busy), 16'd0);
            chk("imm_ovf", 16'(ovf), 16'(m_ovf));
            tick();
            chk("imm_done_drop", 16'(done), 16'd0);
            chk("imm_busy_after", 16'(busy), 16'd0);
            return;
        end
        m_ovf = 1'b0;
        for (int k = 0; k < 14; k++) begin
            chk("conv_busy", 16'(busy), 16'd1);
            chk("conv_done", 16'(done), 16'd0);
            chk("conv_hold", disp_data, old);
            chk("conv_ovf", 16'(ovf), 16'd0);
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                m_disp = 16'h0000;
                chk("rst_disp", disp_data, 16'h0000);
                chk("rst_busy", 16'(busy), 16'd0);
                chk("rst_done", 16'(done), 16'd0);
                chk("rst_ovf", 16'(ovf), 16'd0);
                repeat (16) begin
                    tick();
                    chk("rst_no_done", 16'(done), 16'd0);
                    chk("rst_no_busy", 16'(busy), 16'd0);
                    chk("rst_disp_hold", disp_data, 16'h0000);
                end
                return;
            end
            if (k == poke) begin
                start    = 1'b1;
                bin      = 16'd1111;
                hex_mode = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        m_disp = bcd(int'(v));
        chk("res_disp", disp_data, m_disp);
        chk("res_done", 16'(done), 16'd1);
        chk("res_busy", 16'(busy), 16'd0);
        chk("res_ovf", 16'(ovf), 16'd0);
        tick();
        chk("res_done_drop", 16'(done), 16'd0);
        chk("res_disp_hold", disp_data, m_disp);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        bin      = 16'h0000;
        hex_mode = 1'b0;
        m_disp   = 16'h0000;
        m_ovf    = 1'b0;
        tick();
        tick();
        chk("reset_disp", disp_data, 16'h0000);
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_done", 16'(done), 16'd0);
        chk("reset_ovf", 16'(ovf), 16'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 16'(busy), 16'd0);

        request(16'd1234, 1'b0, -1, -1);
        request(16'd0, 1'b0, -1, -1);
        request(16'd9, 1'b0, -1, -1);
        request(16'd9999, 1'b0, -1, -1);
        request(16'd10000, 1'b0, -1, -1);
        request(16'hFFFF, 1'b0, -1, -1);
        chk("ovf_sticky", 16'(ovf), 16'd1);
        request(16'd42, 1'b0, -1, -1);
        request(16'hBEEF, 1'b1, -1, -1);
        request(16'd5678, 1'b0, 4, -1);
        request(16'd4321, 1'b0, -1, 7);
        request(16'd8765, 1'b0, -1, -1);

        // two consecutive immediate requests give back-to-back done
        start    = 1'b1;
        hex_mode = 1'b1;
        bin      = 16'hA5C3;
        tick();
        chk("b2b_disp0", disp_data, 16'hA5C3);
        chk("b2b_done0", 16'(done), 16'd1);
        hex_mode = 1'b0;
        bin      = 16'd50000;
        tick();
        start = 1'b0;
        m_disp = 16'h9999;
        chk("b2b_disp1", disp_data, 16'h9999);
        chk("b2b_done1", 16'(done), 16'd1);
        chk("b2b_ovf1", 16'(ovf), 16'd1);
        tick();
        chk("b2b_done_drop", 16'(done), 16'd0);

        for (int i = 0; i < 24; i++) begin
            logic [15:0] v;
            bit          hx;
            hx = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1)
                v = 16'($urandom_range(0, 9999));
            else
                v = 16'($urandom);
            request(v, hx, ($urandom_range(0, 2) == 0) ?
                    int'($urandom_range(0, 12)) : -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
